// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, default geometry and requester IDs for the SRAM
// access controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        READ_WAIT
    } state_e;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input request picker. Round-robin against the last winner by default;
// SRAM_ARB_FIXED_PRIO_EN selects fixed priority with requester 0 first.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
`ifndef SRAM_ARB_FIXED_PRIO_EN
    input  logic last_i,
`endif
    output logic winner_o
);

    always_comb begin
        winner_o = REQ0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        if (req1_i && !req0_i) winner_o = REQ1;
`else
        // On contention the requester that did not win last time goes next.
        if (req0_i && req1_i) winner_o = ~last_i;
        else if (req1_i)      winner_o = REQ1;
`endif
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-requester controller for the flip-flop SRAM: one single-word access at a
// time, registered outputs, tagged read return. SRAM_ARB_FIXED_PRIO_EN selects
// fixed priority instead of round-robin.
module sram_arb_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid,
    output logic              rid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              rvalid_q, rvalid_d;
    logic              rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              win;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic last_q, last_d;

    rr_arb2 u_arb (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (last_q),
        .winner_o (win)
    );
`else
    rr_arb2 u_arb (
        .req0_i   (req0),
        .req1_i   (req1),
        .winner_o (win)
    );
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= REQ0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rid_q       <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q      <= REQ1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    // Request fields are latched into the registered memory-port outputs on
    // the IDLE->ACCESS edge, so ACCESS decides write/read from mem_we_q.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid_d    = 1'b0;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d     = ACCESS;
                    owner_d     = win;
                    gnt0_d      = (win == REQ0);
                    gnt1_d      = (win == REQ1);
                    mem_en_d    = 1'b1;
                    mem_we_d    = (win == REQ1) ? we1 : we0;
                    mem_addr_d  = (win == REQ1) ? addr1 : addr0;
                    mem_wdata_d = !mem_we_d ? '0 : ((win == REQ1) ? wdata1 : wdata0);
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_d      = win;
`endif
                end
            end
            ACCESS:    state_d = mem_we_q ? IDLE : READ_WAIT;
            READ_WAIT: begin
                state_d  = IDLE;
                rvalid_d = 1'b1;
                rid_d    = owner_q;
                rdata_d  = mem_rdata;
            end
            default:   state_d = IDLE;
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid    = rvalid_q;
    assign rid       = rid_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: vector table, directed corner sequences and random
// traffic, all cross-checked cycle by cycle against a transaction-level model.
module tb_sram_arb_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid, rid;
    logic [7:0] rdata;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_arb_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Stub SRAM: registered read, data valid the cycle after the strobe.
    logic       mem_clr;
    logic [7:0] smem [16];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) smem[i] <= 8'hC0 | 8'(i);
        end else if (mem_en) begin
            if (mem_we) smem[mem_addr] <= mem_wdata;
            else        mem_rdata <= smem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works in edge numbers: a request seen at edge e while the controller is
    // free is granted during cycle e; writes free it at e+2, reads at e+3 and
    // return data during cycle e+2.
    int         e = 0;
    logic       s_rst, s_r0, s_r1, s_w0, s_w1;
    logic [3:0] s_a0, s_a1;
    logic [7:0] s_d0, s_d1;

    always @(posedge clk) begin
        e++;
        s_rst = reset_n; s_r0 = req0; s_r1 = req1; s_w0 = we0; s_w1 = we1;
        s_a0 = addr0; s_a1 = addr1; s_d0 = wdata0; s_d1 = wdata1;
    end

    logic [7:0] mmem [16];
    logic       m_init = 1'b0;
    int         m_free = 0, m_rv_at = -1;
    logic       m_rv_id, m_rid, m_win;
    logic [7:0] m_rv_data, m_rdata;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic       m_last;
`endif
    logic       x_g0, x_g1, x_en, x_we, x_rv, x_ad;
    logic [3:0] x_addr;
    logic [7:0] x_wd;

    always @(negedge clk) begin
        if (!m_init) begin
            for (int i = 0; i < 16; i++) mmem[i] = 8'hC0 | 8'(i);
            m_init = 1'b1;
        end
        if (e > 0) begin
            x_g0 = 1'b0; x_g1 = 1'b0; x_en = 1'b0; x_we = 1'b0; x_rv = 1'b0; x_ad = 1'b0;
            if (!s_rst) begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
                m_last = 1'b1;
`endif
                m_free = e + 1; m_rv_at = -1; m_rid = 1'b0; m_rdata = 8'h00;
                x_addr = 4'h0; x_wd = 8'h00; x_ad = 1'b1;
            end else begin
                if (e >= m_free && (s_r0 || s_r1)) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                    m_win = !s_r0;
`else
                    m_win = (s_r0 && s_r1) ? !m_last : s_r1;
                    m_last = m_win;
`endif
                    x_g0 = !m_win; x_g1 = m_win; x_en = 1'b1; x_ad = 1'b1;
                    x_we   = m_win ? s_w1 : s_w0;
                    x_addr = m_win ? s_a1 : s_a0;
                    x_wd   = x_we ? (m_win ? s_d1 : s_d0) : 8'h00;
                    if (x_we) begin
                        mmem[x_addr] = x_wd;
                        m_free = e + 2;
                    end else begin
                        m_free = e + 3; m_rv_at = e + 2;
                        m_rv_id = m_win; m_rv_data = mmem[x_addr];
                    end
                end
                if (e == m_rv_at) begin
                    x_rv = 1'b1; m_rid = m_rv_id; m_rdata = m_rv_data;
                end
            end
            chk("m_gnt0", 32'(gnt0), 32'(x_g0));
            chk("m_gnt1", 32'(gnt1), 32'(x_g1));
            chk("m_mem_en", 32'(mem_en), 32'(x_en));
            chk("m_mem_we", 32'(mem_we), 32'(x_we));
            chk("m_rvalid", 32'(rvalid), 32'(x_rv));
            chk("m_rid", 32'(rid), 32'(m_rid));
            chk("m_rdata", 32'(rdata), 32'(m_rdata));
            if (x_ad) begin
                chk("m_mem_addr", 32'(mem_addr), 32'(x_addr));
                chk("m_mem_wdata", 32'(mem_wdata), 32'(x_wd));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic       r0, r1, w0, w1;
        logic [3:0] a0, a1;
        logic [7:0] d0, d1;
        logic       ewin, ewe;
        logic [3:0] eaddr;
        logic [7:0] ewd, erd;
    } vec_t;
    vec_t tv [6];

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(gnt0 || gnt1) && k < 12);
        if (!(gnt0 || gnt1)) begin
            checks++; errors++;
            $display("FAIL %s: no grant within %0d cycles", name, k);
        end
    endtask

    // Keep pending requests up until granted.
    task automatic serve();
        int k;
        k = 0;
        while ((req0 || req1) && k < 12) begin
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            k++;
        end
        if (req0 || req1) begin
            checks++; errors++;
            $display("FAIL serve: request still pending after %0d cycles", k);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, lastc;
        logic [3:0] cexp;

        tv[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 8'hA5, 8'h00, 1'b0, 1'b1, 4'h3, 8'hA5, 8'h00};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h3, 8'h00, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00, 8'hA5};
        tv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 8'h00, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 8'hC0};
        tv[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 4'h0, 8'h33, 8'h00, 1'b0, 1'b1, 4'h7, 8'h33, 8'h00};
`ifdef SRAM_ARB_FIXED_PRIO_EN
        tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h6, 8'h00, 8'h00, 1'b0, 1'b0, 4'h5, 8'h00, 8'hC5};
        tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h8, 4'h9, 8'h11, 8'h22, 1'b0, 1'b1, 4'h8, 8'h11, 8'h00};
        cexp  = 4'b0000;
`else
        tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 4'h6, 8'h00, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00, 8'hC6};
        tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h8, 4'h9, 8'h11, 8'h22, 1'b1, 1'b1, 4'h9, 8'h22, 8'h00};
        cexp  = 4'b1010;
`endif

        // Reset held 3 cycles with a write request pending.
        mem_clr = 1'b1; reset_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'h77;
        req1 = 1'b0; we1 = 1'b0; addr1 = 4'h0; wdata1 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_clr = 1'b0;
            chk("rst_gnt0", 32'(gnt0), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_rvalid", 32'(rvalid), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_first_gnt0", 32'(gnt0), 1);
        req0 = 1'b0;
        idle(3);

        foreach (tv[i]) begin
            req0 = tv[i].r0; req1 = tv[i].r1; we0 = tv[i].w0; we1 = tv[i].w1;
            addr0 = tv[i].a0; addr1 = tv[i].a1; wdata0 = tv[i].d0; wdata1 = tv[i].d1;
            wait_gnt("tv_gnt");
            chk("tv_gnt1", 32'(gnt1), 32'(tv[i].ewin));
            chk("tv_gnt0", 32'(gnt0), 32'(!tv[i].ewin));
            chk("tv_mem_we", 32'(mem_we), 32'(tv[i].ewe));
            chk("tv_mem_addr", 32'(mem_addr), 32'(tv[i].eaddr));
            chk("tv_mem_wdata", 32'(mem_wdata), 32'(tv[i].ewd));
            if (tv[i].ewin) req1 = 1'b0; else req0 = 1'b0;
            if (!tv[i].ewe) begin
                @(negedge clk);
                chk("tv_rvalid_early", 32'(rvalid), 0);
                @(negedge clk);
                chk("tv_rvalid", 32'(rvalid), 1);
                chk("tv_rid", 32'(rid), 32'(tv[i].ewin));
                chk("tv_rdata", 32'(rdata), 32'(tv[i].erd));
            end
            serve();
            idle(3);
        end

        // Back-to-back writes over the whole address range.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'h0; wdata0 = 8'h3C; k = 0; lastc = 0;
        for (int c = 0; c < 60 && k < 16; c++) begin
            @(negedge clk);
            if (gnt0) begin
                chk("b2b_addr", 32'(mem_addr), k);
                if (k > 0) chk("b2b_gap", c - lastc, 2);
                lastc = c; k++;
                if (k == 16) req0 = 1'b0;
                else begin
                    addr0 = 4'(k); wdata0 = 8'h3C ^ 8'(k);
                end
            end
        end
        chk("b2b_count", k, 16);
        idle(3);

        // Reset during READ_WAIT abandons the read.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h4;
        wait_gnt("midrd_gnt");
        req1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrd_rvalid", 32'(rvalid), 0);
        chk("midrd_mem_en", 32'(mem_en), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrd_rvalid_after", 32'(rvalid), 0);

        // Contention: both hold read requests, first four winners.
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'hA; addr1 = 4'hB; k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                chk("cont_win", 32'(gnt1), 32'(cexp[k]));
                k++;
                if (k == 4) begin
                    if (gnt1) req1 = 1'b0; else req0 = 1'b0;
                end
            end
        end
        chk("cont_count", k, 4);
        serve();
        idle(4);

        // Requester 1 alone, three reads.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'h1; k = 0; lastc = 0;
        for (int c = 0; c < 30 && k < 3; c++) begin
            @(negedge clk);
            chk("single_gnt0", 32'(gnt0), 0);
            if (gnt1) begin
                if (k > 0) chk("single_gap", c - lastc, 3);
                lastc = c; k++;
                addr1 = addr1 + 4'h1;
                if (k == 3) req1 = 1'b0;
            end
        end
        chk("single_count", k, 3);
        idle(4);

        // Random traffic; the model checks every cycle.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                addr0 = 4'($urandom); wdata0 = 8'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                addr1 = 4'($urandom); wdata1 = 8'($urandom);
            end
        end
        serve();
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Two-requester access controller for the flip-flop SRAM array. It arbitrates between requester 0 and requester 1 and sequences one single-word read or write at a time onto the array's port. It also returns read data tagged with the requester ID. It sits between the client logic and the SRAM word array built from D flip-flop cells.

## Interface
- ADDR_W, 4: SRAM address width (2^ADDR_W words)
- DATA_W, 8: SRAM word width
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset (sampled on clk rising edge)
- req0 / req1  in  1  access request from requester 0 / 1; held high until granted
- we0 / we1  in  1  1 = write, 0 = read; held stable with req
- addr0 / addr1  in  ADDR_W  word address; held stable with req
- wdata0 / wdata1  in  DATA_W  write data; held stable with req
- gnt0 / gnt1  out  1  one-cycle grant pulse; request fields are consumed in that cycle
- rvalid  out  1  one-cycle pulse: rdata/rid are valid
- rid  out  1  requester that issued the returned read
- rdata  out  DATA_W  read data
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write enable (meaningful only with mem_en)
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data; valid the cycle after a read strobe

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: grant and memory strobe active.
  - READ_WAIT: waiting for SRAM read data.
- Transitions:
  - IDLE -> ACCESS when req0 | req1; requests are sampled at the edge leaving IDLE.
  - ACCESS -> IDLE if the granted op is a write.
  - ACCESS -> READ_WAIT if the granted op is a read.
  - READ_WAIT -> IDLE unconditionally; mem_rdata and the requester ID are captured at this edge.
- Arbitration, round-robin: a `last` register holds the most recently granted requester.
  - When both requests are high, the other requester (not `last`) wins.
  - A single request always wins.
  - `last` updates on entry to ACCESS.
- All outputs are registered and decoded from state plus the latched request.
- In ACCESS, for exactly one cycle:
  - the winner's gntN is high;
  - mem_en = 1, mem_we = latched we, mem_addr = latched addr;
  - mem_wdata = latched wdata for writes, 0 for reads.
- Outside ACCESS, mem_en, mem_we and both grants are 0.
- rvalid is high for one cycle, the cycle after READ_WAIT, with rdata and rid. rdata and rid hold their value until the next rvalid.
- No request queuing: the losing requester keeps req high and is re-arbitrated on the next IDLE.
- A req dropped before its gnt is a protocol error; the controller needs no defined behaviour for it.
- Reset values (reset_n = 0 at an edge):
  - state = IDLE, `last` = 1 so requester 0 is favoured first;
  - gnt0 = gnt1 = rvalid = rid = 0;
  - rdata = 0, mem_en = mem_we = 0, mem_addr = mem_wdata = 0.
- Reset mid-operation: an in-flight read is abandoned and no rvalid is produced. A write already strobed is not undone.

## Timing
- Request seen in IDLE at edge E0: gnt and mem_en are high in cycle E0..E1.
- Write: complete at E1; back in IDLE at E1, so a new grant is possible in cycle E2..E3.
- Read: mem_rdata is valid in cycle E1..E2 and captured at E2; rvalid is high in E2..E3.
  - Rising edge to rvalid: 2 cycles after the grant cycle starts.
  - State is IDLE during the rvalid cycle, so the next grant can overlap the rvalid-following cycle.
- Throughput: one write per 2 cycles; one read per 3 cycles.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN defined:
  - requester 0 always wins when both requests are high;
  - the `last` register and round-robin logic are removed.
- SRAM_ARB_FIXED_PRIO_EN undefined: round-robin as above.

## Structure
- Package sram_ctrl_pkg:
  - FSM state enum (IDLE, ACCESS, READ_WAIT);
  - default ADDR_W/DATA_W constants;
  - requester-ID constants REQ0 = 0, REQ1 = 1.
- Sub-module rr_arb2: 2-input round-robin picker (req0, req1, last -> winner). Its fixed-priority variant is selected by the macro.
- The SRAM array itself is outside this block.

## Test plan
- Reset: hold reset_n = 0 for 3 cycles with req0 = 1 -> all outputs 0, no gnt; after release, gnt0 pulses on the first IDLE edge.
- Write then read: req0, we0 = 1, addr0 = 4'h3, wdata0 = 8'hA5 -> mem_en = mem_we = 1, mem_addr = 3 for one cycle. Then req1 read of addr 3 with a stub SRAM -> rvalid = 1, rid = 1, rdata = 8'hA5 exactly 2 cycles after gnt1.
- Contention: req0 and req1 both held high for 4 reads -> grants alternate 0,1,0,1 (fixed-priority build: 0,0,0,0 while req0 is held).
- Back-to-back writes from one requester at addresses 0..15 -> one gnt every 2 cycles, mem_addr increments, no missed or duplicate strobe.
- Reset mid-read: assert reset_n = 0 in the READ_WAIT cycle -> no rvalid, state returns to IDLE, next request is granted normally.
- Single requester with idle other: req1 alone, 3 reads -> gnt1 every 3 cycles, gnt0 never asserted, rid = 1 on each rvalid.
